// File: rtl/bus_mem_responder.sv
// Memory-side responder for the 8-bit processor bus: asynchronous-read RAM,
// a byte-stream program loader that holds the CPU in reset, and a watch-address capture.
module bus_mem_responder #(
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 64,
   parameter int WATCH_ADDR = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              we,
   output logic [DATA_W-1:0] data_out,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              cpu_run,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   output logic [7:0]        wr_count
);

   typedef enum logic {
      S_LOAD = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] load_ptr_q;
   logic [ADDR_W-1:0] load_ptr_d;
   logic              load_ready_q;
   logic              cpu_run_q;
   logic [DATA_W-1:0] result_q;
   logic              result_valid_q;
   logic [7:0]        wr_count_q;
   logic [7:0]        wr_count_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic load_xfer;
   logic cpu_wr;
   logic watch_hit;
   logic ptr_last;

   // Writes presented in a reset cycle are dropped, both from the loader and the CPU.
   assign load_xfer = (state_q == S_LOAD) && load_valid && !rst;
   assign cpu_wr    = (state_q == S_RUN) && we && !rst;
   assign watch_hit = (addr == ADDR_W'(WATCH_ADDR));
   assign ptr_last  = (load_ptr_q == ADDR_W'(DEPTH - 1));

   always_comb begin
      load_ptr_d = load_ptr_q + 1'b1;
      wr_count_d = (wr_count_q == 8'hFF) ? wr_count_q : wr_count_q + 8'd1;
   end

   // Memory has no reset so a program survives a CPU restart.
   always_ff @(posedge clk) begin
      if (load_xfer) begin
         mem_q[load_ptr_q] <= load_data;
      end else if (cpu_wr) begin
         mem_q[addr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_LOAD;
         load_ptr_q     <= '0;
         load_ready_q   <= 1'b1;
         cpu_run_q      <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         wr_count_q     <= 8'd0;
      end else begin
         result_valid_q <= 1'b0;
         case (state_q)
            S_LOAD: begin
               if (load_xfer) begin
                  load_ptr_q <= load_ptr_d;
                  if (load_last || ptr_last) begin
                     state_q      <= S_RUN;
                     load_ready_q <= 1'b0;
                     cpu_run_q    <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (we) begin
                  wr_count_q <= wr_count_d;
                  if (watch_hit) begin
                     result_q       <= data_in;
                     result_valid_q <= 1'b1;
                  end
               end
            end
            default: state_q <= S_LOAD;
         endcase
      end
   end

   // Zero-latency read matches the CPU's asynchronous-read timing.
   assign data_out     = (state_q == S_RUN) ? mem_q[addr] : '0;
   assign load_ready   = load_ready_q;
   assign cpu_run      = cpu_run_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder: randomized traffic against a
// behavioural memory/loader model held in plain arrays and counters.
module tb_bus_mem_responder;

   logic       clk;
   logic       rst;
   logic [5:0] addr;
   logic [7:0] data_in;
   logic       we;
   logic [7:0] data_out;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_last;
   logic       load_ready;
   logic       cpu_run;
   logic [7:0] result;
   logic       result_valid;
   logic [7:0] wr_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] m_mem [64];
   int         m_ptr;
   bit         m_run;
   logic [7:0] m_result;
   bit         m_rv;
   int         m_cnt;

   bus_mem_responder #(
      .ADDR_W(6), .DATA_W(8), .DEPTH(64), .WATCH_ADDR(14)
   ) dut (
      .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .we(we),
      .data_out(data_out), .load_valid(load_valid), .load_data(load_data),
      .load_last(load_last), .load_ready(load_ready), .cpu_run(cpu_run),
      .result(result), .result_valid(result_valid), .wr_count(wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      m_ptr = 0; m_run = 0; m_result = 8'h00; m_rv = 0; m_cnt = 0;
   endtask

   task automatic load_byte(input logic [7:0] b, input bit last);
      load_valid = 1'b1;
      load_data  = b;
      load_last  = last;
      step();
      load_valid = 1'b0;
      load_last  = 1'b0;
      if (!m_run) begin
         m_mem[m_ptr] = b;
         m_ptr = (m_ptr + 1) % 64;
         if (last || m_ptr == 0) m_run = 1;
      end
   endtask

   task automatic cpu_cycle(input logic [5:0] a, input logic [7:0] d, input bit w);
      addr = a; data_in = d; we = w;
      step();
      we = 1'b0;
      m_rv = 0;
      if (m_run && w) begin
         m_mem[a] = d;
         if (m_cnt < 255) m_cnt++;
         if (a == 6'd14) begin
            m_rv = 1;
            m_result = d;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_run got=%b exp=0", cpu_run); end
      n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready got=%b exp=1", load_ready); end
      n_checks++; if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result got=%h exp=00", result); end
      n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_result_valid got=%b exp=0", result_valid); end
      n_checks++; if (wr_count !== 8'd0) begin n_fail++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
      addr = 6'd0; #1;
      n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
   endtask

   task automatic test_load_normal();
      logic [7:0] b;
      for (int i = 0; i < 16; i++) begin
         b = (i == 0) ? 8'h0F : (i == 15) ? 8'h04 : 8'($urandom);
         if (i == 15) begin
            n_checks++; if (load_ready !== 1'b1 || cpu_run !== 1'b0) begin
               n_fail++; $display("FAIL load_pre_last ready=%b run=%b exp ready=1 run=0", load_ready, cpu_run); end
         end
         load_byte(b, i == 15);
      end
      n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_after_last got=%b exp=0", load_ready); end
      n_checks++; if (cpu_run !== 1'b1) begin n_fail++; $display("FAIL cpu_run_after_last got=%b exp=1", cpu_run); end
      for (int k = 0; k < 16; k++) begin
         addr = 6'(k);
         @(negedge clk);
         n_checks++; if (data_out !== m_mem[k]) begin
            n_fail++; $display("FAIL load_readback addr=%0d got=%h exp=%h", k, data_out, m_mem[k]); end
      end
      addr = 6'd0; @(negedge clk);
      n_checks++; if (data_out !== 8'h0F) begin n_fail++; $display("FAIL read_addr0 got=%h exp=0F", data_out); end
      addr = 6'd15; @(negedge clk);
      n_checks++; if (data_out !== 8'h04) begin n_fail++; $display("FAIL read_addr15 got=%h exp=04", data_out); end
   endtask

   task automatic test_load_wrap();
      do_reset();
      for (int k = 0; k < 64; k++) begin
         while ($urandom_range(0, 2) == 0) begin
            load_valid = 1'b0;
            load_data  = 8'($urandom);
            step();
         end
         n_checks++; if (cpu_run !== 1'b0 || load_ready !== 1'b1) begin
            n_fail++; $display("FAIL wrap_still_loading byte=%0d run=%b ready=%b exp run=0 ready=1", k, cpu_run, load_ready); end
         load_byte(8'(k), 1'b0);
      end
      n_checks++; if (cpu_run !== 1'b1 || load_ready !== 1'b0) begin
         n_fail++; $display("FAIL wrap_enter_run run=%b ready=%b exp run=1 ready=0", cpu_run, load_ready); end
      for (int k = 0; k < 64; k++) begin
         addr = 6'(k);
         @(negedge clk);
         n_checks++; if (data_out !== 8'(k)) begin
            n_fail++; $display("FAIL wrap_readback addr=%0d got=%h exp=%h", k, data_out, 8'(k)); end
      end
   endtask

   task automatic test_watch();
      cpu_cycle(6'd14, 8'h20, 1'b1);
      n_checks++; if (result !== 8'h20 || result_valid !== 1'b1) begin
         n_fail++; $display("FAIL watch_first result=%h rv=%b exp result=20 rv=1", result, result_valid); end
      n_checks++; if (wr_count !== 8'd1) begin n_fail++; $display("FAIL watch_count1 got=%0d exp=1", wr_count); end
      step();
      n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL watch_pulse_width got=%b exp=0", result_valid); end
      cpu_cycle(6'd13, 8'h77, 1'b1);
      n_checks++; if (result_valid !== 1'b0 || result !== 8'h20) begin
         n_fail++; $display("FAIL watch_other_addr rv=%b result=%h exp rv=0 result=20", result_valid, result); end
      n_checks++; if (wr_count !== 8'd2) begin n_fail++; $display("FAIL watch_count2 got=%0d exp=2", wr_count); end
      cpu_cycle(6'd14, 8'h01, 1'b1);
      n_checks++; if (result_valid !== 1'b1 || result !== 8'h01) begin
         n_fail++; $display("FAIL watch_b2b_1 rv=%b result=%h exp rv=1 result=01", result_valid, result); end
      cpu_cycle(6'd14, 8'h02, 1'b1);
      n_checks++; if (result_valid !== 1'b1 || result !== 8'h02) begin
         n_fail++; $display("FAIL watch_b2b_2 rv=%b result=%h exp rv=1 result=02", result_valid, result); end
      step();
      n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL watch_b2b_end got=%b exp=0", result_valid); end
      n_checks++; if (wr_count !== 8'(m_cnt)) begin n_fail++; $display("FAIL watch_count4 got=%0d exp=%0d", wr_count, m_cnt); end
   endtask

   task automatic test_rw_order();
      cpu_cycle(6'd5, 8'hAA, 1'b1);
      addr = 6'd5; data_in = 8'h55; we = 1'b1;
      @(negedge clk);
      n_checks++; if (data_out !== 8'hAA) begin n_fail++; $display("FAIL rw_before_edge got=%h exp=AA", data_out); end
      step();
      we = 1'b0;
      m_mem[5] = 8'h55; if (m_cnt < 255) m_cnt++; m_rv = 0;
      n_checks++; if (data_out !== 8'h55) begin n_fail++; $display("FAIL rw_after_edge got=%h exp=55", data_out); end
   endtask

   task automatic test_random_run();
      logic [5:0] a;
      logic [7:0] d;
      bit         w;
      for (int i = 0; i < 60; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 6'd14 : 6'($urandom);
         d = 8'($urandom);
         w = ($urandom_range(0, 1) == 1);
         addr = a; data_in = d; we = w;
         @(negedge clk);
         n_checks++; if (data_out !== m_mem[a]) begin
            n_fail++; $display("FAIL rand_read i=%0d addr=%0d got=%h exp=%h", i, a, data_out, m_mem[a]); end
         cpu_cycle(a, d, w);
         n_checks++; if (result_valid !== m_rv || result !== m_result || wr_count !== 8'(m_cnt)) begin
            n_fail++; $display("FAIL rand_state i=%0d rv=%b res=%h cnt=%0d exp rv=%b res=%h cnt=%0d",
                               i, result_valid, result, wr_count, m_rv, m_result, m_cnt); end
      end
   endtask

   task automatic test_reset_midload();
      logic [7:0] old3;
      logic [7:0] c2;
      do_reset();
      old3 = m_mem[3];
      load_byte(8'($urandom), 1'b0);
      load_byte(8'($urandom), 1'b0);
      c2 = 8'($urandom);
      load_byte(c2, 1'b0);
      load_valid = 1'b1; load_data = ~old3; rst = 1'b1;
      step();
      rst = 1'b0; load_valid = 1'b0;
      m_ptr = 0; m_run = 0; m_result = 8'h00; m_rv = 0; m_cnt = 0;
      n_checks++; if (cpu_run !== 1'b0 || load_ready !== 1'b1) begin
         n_fail++; $display("FAIL midload_rst run=%b ready=%b exp run=0 ready=1", cpu_run, load_ready); end
      addr = 6'd3; #1;
      n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL midload_data_out got=%h exp=00", data_out); end
      load_byte(8'($urandom), 1'b0);
      load_byte(8'($urandom), 1'b1);
      n_checks++; if (cpu_run !== 1'b1) begin n_fail++; $display("FAIL reload_run got=%b exp=1", cpu_run); end
      for (int k = 0; k < 4; k++) begin
         addr = 6'(k);
         @(negedge clk);
         n_checks++; if (data_out !== m_mem[k]) begin
            n_fail++; $display("FAIL reload_read addr=%0d got=%h exp=%h", k, data_out, m_mem[k]); end
      end
      n_checks++; if (m_mem[2] !== c2 || m_mem[3] !== old3) begin
         n_fail++; $display("FAIL reload_model_keep m2=%h m3=%h exp m2=%h m3=%h", m_mem[2], m_mem[3], c2, old3); end
   endtask

   task automatic test_sat_reset();
      logic [7:0] old20;
      for (int i = 0; i < 300; i++) begin
         cpu_cycle(6'($urandom), 8'($urandom), 1'b1);
         if (i == 254) begin
            n_checks++; if (wr_count !== 8'd255) begin n_fail++; $display("FAIL sat_reach got=%0d exp=255", wr_count); end
         end
      end
      n_checks++; if (wr_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold got=%0d exp=255", wr_count); end
      cpu_cycle(6'd14, 8'h9C, 1'b1);
      n_checks++; if (result !== 8'h9C || result_valid !== 1'b1) begin
         n_fail++; $display("FAIL sat_watch result=%h rv=%b exp result=9C rv=1", result, result_valid); end
      old20 = m_mem[20];
      addr = 6'd20; data_in = ~old20; we = 1'b1; rst = 1'b1;
      step();
      rst = 1'b0; we = 1'b0;
      m_ptr = 0; m_run = 0; m_result = 8'h00; m_rv = 0; m_cnt = 0;
      n_checks++; if (wr_count !== 8'd0 || result !== 8'h00 || result_valid !== 1'b0) begin
         n_fail++; $display("FAIL run_rst_clear cnt=%0d res=%h rv=%b exp 0/00/0", wr_count, result, result_valid); end
      n_checks++; if (cpu_run !== 1'b0 || load_ready !== 1'b1) begin
         n_fail++; $display("FAIL run_rst_state run=%b ready=%b exp run=0 ready=1", cpu_run, load_ready); end
      load_byte(8'($urandom), 1'b1);
      addr = 6'd20;
      @(negedge clk);
      n_checks++; if (data_out !== old20) begin n_fail++; $display("FAIL run_rst_no_write got=%h exp=%h", data_out, old20); end
   endtask

   initial begin
      rst = 1'b0; addr = '0; data_in = '0; we = 1'b0;
      load_valid = 1'b0; load_data = '0; load_last = 1'b0;
      test_reset();
      test_load_normal();
      test_load_wrap();
      test_watch();
      test_rw_order();
      test_random_run();
      test_reset_midload();
      test_sat_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
